// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, slot geometry and address decode for the APB requester.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_SLOT_SHIFT = 12;
    localparam int APB_IDX_W_MAX  = 16;

    typedef struct packed {
        logic                     hit;
        logic [APB_IDX_W_MAX-1:0] idx;
    } apb_decode_t;

    // Operands are widened to 64 bits so the same function serves any ADDR_WIDTH up to 64.
    function automatic apb_decode_t apb_decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned num_slaves
    );
        apb_decode_t res;
        logic [63:0] slot;
        slot    = (addr - base) >> APB_SLOT_SHIFT;
        res.hit = (addr >= base) && (slot < 64'(num_slaves));
        res.idx = slot[APB_IDX_W_MAX-1:0];
        return res;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational peripheral-window decode: address to hit, slot index and one-hot select.
module apb_addr_decoder #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             NUM_SLAVES = 4,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned             IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_hit,
    output logic [IDX_W-1:0]      o_idx,
    output logic [NUM_SLAVES-1:0] o_sel
);
    import apb_pkg::*;

    apb_decode_t w_dec;

    always_comb begin
        w_dec = apb_decode(64'(i_addr), 64'(BASE_ADDR), NUM_SLAVES);
        o_hit = w_dec.hit;
        o_idx = w_dec.hit ? w_dec.idx[IDX_W-1:0] : '0;
        o_sel = '0;
        // Full-width index compare keeps out-of-range slots from aliasing onto a low select bit.
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            o_sel[i] = w_dec.hit && (w_dec.idx == APB_IDX_W_MAX'(i));
        end
    end

endmodule

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB3 requester bridging the core load/store port onto the peripheral bus.
// Optional ACCESS-phase timeout enabled by defining APB_REQ_TIMEOUT_EN.
module apb_requester #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           NUM_SLAVES     = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);
    import apb_pkg::*;

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    apb_state_e              r_state;
    apb_state_e              w_next;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_SLAVES-1:0]   r_sel;

    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic [NUM_SLAVES-1:0]   w_sel;
    logic                    w_ready;
    logic                    w_slverr;
    logic [DATA_WIDTH-1:0]   w_prdata;
    logic                    w_timeout;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .i_addr (req_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx),
        .o_sel  (w_sel)
    );

    // Only the latched slot's completer signals are ever looked at.
    assign w_ready  = PREADY[r_idx];
    assign w_slverr = PSLVERR[r_idx];
    assign w_prdata = PRDATA[r_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_REQ_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_ready) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Fires in the wait cycle that brings the count to TIMEOUT_CYCLES; a PREADY in that cycle wins.
    assign w_timeout = (r_state == ACCESS) && !w_ready &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    wire w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = w_hit ? SETUP : RESP;
                end
            end
            SETUP:   w_next = ACCESS;
            ACCESS: begin
                if (w_ready || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_idx   <= w_idx;
                        r_sel   <= w_sel;
                        r_err   <= !w_hit;
                        r_rdata <= '0;
                    end
                end
                ACCESS: begin
                    if (w_ready) begin
                        r_rdata <= (r_write || w_slverr) ? '0 : w_prdata;
                        r_err   <= w_slverr;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs decode straight from state so an asynchronous reset drops them at once.
    assign req_ready = (r_state == IDLE);
    assign PSEL      = ((r_state == SETUP) || (r_state == ACCESS)) ? r_sel : '0;
    assign PENABLE   = (r_state == ACCESS);
    assign PADDR     = r_addr;
    assign PWRITE    = r_write;
    assign PWDATA    = r_wdata;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = rsp_valid ? r_rdata : '0;
    assign rsp_err   = rsp_valid & r_err;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - scoreboard bench for apb_requester with a wait-state completer model.
module tb_apb_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [AW-1:0]      req_addr;
    logic [DW-1:0]      req_wdata;
    logic               rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic [AW-1:0]      PADDR;
    logic [NS-1:0]      PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [DW-1:0]      PWDATA;
    logic [NS*DW-1:0]   PRDATA;
    logic [NS-1:0]      PREADY;
    logic [NS-1:0]      PSLVERR;

    always #5 clk = ~clk;

    apb_requester #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_SLAVES     (NS),
        .BASE_ADDR      (32'h1000_0000),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // Completer model: slot i raises PREADY after waits[i] ACCESS cycles.
    logic [7:0]    waits [NS];
    logic [DW-1:0] slot_data [NS];
    logic [NS-1:0] force_ready;
    logic [NS-1:0] err_cfg;
    int            acc_cnt = 0;

    always @(posedge clk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        PREADY = '0;
        PRDATA = '0;
        for (int i = 0; i < NS; i++) begin
            PREADY[i] = force_ready[i] | (PSEL[i] & PENABLE & (acc_cnt >= int'(waits[i])));
            PRDATA[i*DW +: DW] = slot_data[i];
        end
    end
    assign PSLVERR = err_cfg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            k;
        int            lat;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            check_eq("rsp_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_err", rsp_err, e.err);
                check_eq("rsp_latency", 64'(cyc - e.k), 64'(e.lat));
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic expect_rsp, input logic [DW-1:0] xr, input logic xe,
                        input int lat, output int k);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        k = cyc;
        if (expect_rsp) begin
            e.rdata = xr;
            e.err   = xe;
            e.k     = k;
            e.lat   = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        force_ready = '0;
        err_cfg = '0;
        for (int i = 0; i < NS; i++) begin
            waits[i] = 8'd0;
            slot_data[i] = 32'h0;
        end
        slot_data[0] = 32'h0000_00A5;
        slot_data[1] = 32'h1234_5678;
        slot_data[2] = 32'hCAFE_0002;
        slot_data[3] = 32'hBAD0_0003;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_psel", PSEL, 0);
        check_eq("rst_penable", PENABLE, 0);
        check_eq("rst_paddr", PADDR, 0);
        check_eq("rst_pwdata", PWDATA, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;

        // Zero-wait write to slot 1
        send(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 3, k);
        check_eq("wr_setup_psel", PSEL, 4'b0010);
        check_eq("wr_setup_penable", PENABLE, 0);
        check_eq("wr_setup_pwrite", PWRITE, 1);
        check_eq("wr_setup_paddr", PADDR, 32'h1000_1004);
        check_eq("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check_eq("wr_access_psel", PSEL, 4'b0010);
        check_eq("wr_access_penable", PENABLE, 1);
        check_eq("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
        drain();

        // One-wait read from slot 0
        waits[0] = 8'd1;
        send(1'b0, 32'h1000_0008, 32'h0, 1'b1, 32'h0000_00A5, 1'b0, 4, k);
        check_eq("rd_setup_psel", PSEL, 4'b0001);
        @(posedge clk); #1;
        check_eq("rd_access1_penable", PENABLE, 1);
        @(posedge clk); #1;
        check_eq("rd_access2_penable", PENABLE, 1);
        check_eq("rd_access2_paddr", PADDR, 32'h1000_0008);
        check_eq("rd_access2_pwrite", PWRITE, 0);
        drain();
        waits[0] = 8'd0;

        // Decode misses: above the last slot and just below the window
        send(1'b0, 32'h1000_4000, 32'h0, 1'b1, 32'h0, 1'b1, 1, k);
        check_eq("miss_hi_psel", PSEL, 0);
        drain();
        send(1'b1, 32'h0FFF_FFFC, 32'h1111_2222, 1'b1, 32'h0, 1'b1, 1, k);
        check_eq("miss_lo_psel", PSEL, 0);
        drain();

        // Slave error on slot 2 while slot 3 shouts ready/error
        force_ready[3] = 1'b1;
        err_cfg[3] = 1'b1;
        err_cfg[2] = 1'b1;
        waits[2] = 8'd2;
        send(1'b0, 32'h1000_2010, 32'h0, 1'b1, 32'h0, 1'b1, 5, k);
        check_eq("slverr_psel", PSEL, 4'b0100);
        drain();
        send(1'b0, 32'h1000_1000, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 3, k);
        drain();
        force_ready = '0;
        err_cfg = '0;
        waits[2] = 8'd0;

        // Back-to-back writes keep the four-cycle issue interval
        send(1'b1, 32'h1000_0000, 32'hA0A0_0001, 1'b1, 32'h0, 1'b0, 3, k);
        send(1'b1, 32'h1000_0004, 32'hA0A0_0002, 1'b1, 32'h0, 1'b0, 3, k2);
        check_eq("b2b_interval", 64'(k2 - k), 64'd4);
        drain();

        // Reset in the middle of a stalled ACCESS
        waits[1] = 8'd255;
        send(1'b1, 32'h1000_1000, 32'h0000_0055, 1'b0, 32'h0, 1'b0, 0, k);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_rst_penable", PENABLE, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_psel", PSEL, 0);
        check_eq("rst_async_penable", PENABLE, 0);
        check_eq("rst_async_req_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        waits[1] = 8'd0;
        send(1'b1, 32'h1000_1008, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b0, 3, k);
        check_eq("post_rst_pwdata", PWDATA, 32'h0BAD_F00D);
        drain();

`ifdef APB_REQ_TIMEOUT_EN
        // Timeout after ten wait cycles, then PREADY on the tenth cycle wins
        waits[1] = 8'd255;
        send(1'b0, 32'h1000_1000, 32'h0, 1'b1, 32'h0, 1'b1, 12, k);
        drain();
        waits[1] = 8'd9;
        send(1'b0, 32'h1000_1000, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 12, k);
        drain();
        waits[1] = 8'd0;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
